// File: rtl/exec_dispatcher.sv
// exec_dispatcher: issue-side sequencer for the execute stage.
// Accepts one decoded instruction at a time, starts the selected exec element
// by releasing its reset, waits (bounded) for its completed flag, captures its
// result and issues a single register-file writeback.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   issue_valid/ready       decode handshake (ready only while idle)
//   issue_unit/inst_num/dest/writes   decoded instruction fields
//   unit_reset              per-element reset (1 = held in reset)
//   unit_inst_num           latched instruction number broadcast to elements
//   unit_completed/unit_out per-element completion flag and 32-bit result
//   wb_en/wb_addr/wb_data   register-file write port
//   busy                    dispatcher not idle
//   timeout_pulse/err_flag  abort strobe and sticky error flag
module exec_dispatcher #(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [UW-1:0]           issue_unit,
  input  logic [5:0]              issue_inst_num,
  input  logic [4:0]              issue_dest,
  input  logic                    issue_writes,
  output logic [NUM_UNITS-1:0]    unit_reset,
  output logic [5:0]              unit_inst_num,
  input  logic [NUM_UNITS-1:0]    unit_completed,
  input  logic [32*NUM_UNITS-1:0] unit_out,
  output logic                    wb_en,
  output logic [4:0]              wb_addr,
  output logic [31:0]             wb_data,
  output logic                    busy,
  output logic                    timeout_pulse,
  output logic                    err_flag
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WB
  } state_t;

  state_t               state_q, state_d;
  logic [UW-1:0]        sel_q, sel_d;
  logic [4:0]           dest_q, dest_d;
  logic                 writes_q, writes_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_UNITS-1:0] unit_reset_d;
  logic [5:0]           inst_d;
  logic                 wb_en_d;
  logic [4:0]           wb_addr_d;
  logic [DW-1:0]        wb_data_d;
  logic                 timeout_d;
  logic                 err_d;

  logic                 sel_done_c;
  logic [DW-1:0]        sel_out_c;
  logic [NUM_UNITS-1:0] sel_onehot_c;
  logic                 unit_bad_c;

  // Status decoded straight from the state register.
  assign issue_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);

  // Out-of-range index check done at 32 bits so non-power-of-two counts work.
  assign unit_bad_c = (32'(issue_unit) >= NUM_UNITS);

  // Select the latched element's completion flag and result.
  always_comb begin
    sel_done_c   = 1'b0;
    sel_out_c    = '0;
    sel_onehot_c = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (sel_q == UW'(i)) begin
        sel_onehot_c[i] = 1'b1;
        sel_done_c      = unit_completed[i];
        sel_out_c       = unit_out[DW*i +: DW];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    dest_d       = dest_q;
    writes_d     = writes_q;
    cnt_d        = cnt_q;
    unit_reset_d = unit_reset;
    inst_d       = unit_inst_num;
    wb_en_d      = 1'b0;
    wb_addr_d    = wb_addr;
    wb_data_d    = wb_data;
    timeout_d    = 1'b0;
    err_d        = err_flag;

    unique case (state_q)
      S_IDLE: begin
        unit_reset_d = '1;
        if (issue_valid) begin
          if (unit_bad_c) begin
            // Swallow the instruction without touching any element.
            timeout_d = 1'b1;
            err_d     = 1'b1;
          end else begin
            sel_d    = issue_unit;
            inst_d   = issue_inst_num;
            dest_d   = issue_dest;
            writes_d = issue_writes;
            state_d  = S_START;
          end
        end
      end

      S_START: begin
        // Element stays in reset this cycle, so any completed seen now is stale.
        cnt_d        = '0;
        unit_reset_d = ~sel_onehot_c;
        state_d      = S_WAIT;
      end

      S_WAIT: begin
        if (sel_done_c) begin
          wb_data_d    = sel_out_c;
          wb_addr_d    = dest_q;
          wb_en_d      = writes_q && (dest_q != 5'd0);
          unit_reset_d = '1;
          state_d      = S_WB;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d    = 1'b1;
          err_d        = 1'b1;
          unit_reset_d = '1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WB: begin
        state_d = S_IDLE;
      end

      default: begin
        unit_reset_d = '1;
        state_d      = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      dest_q        <= '0;
      writes_q      <= 1'b0;
      cnt_q         <= '0;
      unit_reset    <= '1;
      unit_inst_num <= '0;
      wb_en         <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      timeout_pulse <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      dest_q        <= dest_d;
      writes_q      <= writes_d;
      cnt_q         <= cnt_d;
      unit_reset    <= unit_reset_d;
      unit_inst_num <= inst_d;
      wb_en         <= wb_en_d;
      wb_addr       <= wb_addr_d;
      wb_data       <= wb_data_d;
      timeout_pulse <= timeout_d;
      err_flag      <= err_d;
    end
  end

endmodule

// File: tb/tb_exec_dispatcher.sv
// Bench for exec_dispatcher: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timestamp-based model.
module tb_exec_dispatcher;

  localparam int unsigned N  = 4;
  localparam int unsigned T  = 4;
  localparam int unsigned UW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic            issue_ready;
  logic [UW-1:0]   issue_unit;
  logic [5:0]      issue_inst_num;
  logic [4:0]      issue_dest;
  logic            issue_writes;
  logic [N-1:0]    unit_reset;
  logic [5:0]      unit_inst_num;
  logic [N-1:0]    unit_completed;
  logic [32*N-1:0] unit_out;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            busy;
  logic            timeout_pulse;
  logic            err_flag;

  exec_dispatcher #(.NUM_UNITS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_unit     (issue_unit),
    .issue_inst_num (issue_inst_num),
    .issue_dest     (issue_dest),
    .issue_writes   (issue_writes),
    .unit_reset     (unit_reset),
    .unit_inst_num  (unit_inst_num),
    .unit_completed (unit_completed),
    .unit_out       (unit_out),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .busy           (busy),
    .timeout_pulse  (timeout_pulse),
    .err_flag       (err_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an instruction accepted at cycle t0 is in START at t0+1,
  // in its WAIT window from t0+2 to t0+1+T, ends either with a writeback the
  // cycle after the completion it sees, or with an abort pulse at t0+2+T.
  // ---------------------------------------------------------------------------
  int          cyc     = 0;
  bit          act     = 1'b0;
  int          t0      = 0;
  int          t_done  = -1;
  int          t_wb    = -1;
  int          t_pulse = -1;
  int          m_sel   = 0;
  logic [4:0]  m_dest  = '0;
  logic        m_writes = 1'b0;
  logic [5:0]  m_inst  = '0;
  logic [31:0] m_wbdata = '0;
  logic        m_err   = 1'b0;
  logic [N-1:0] exp_ur;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_unit_reset", 32'(unit_reset), 32'hF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(issue_ready), 32'd1);
      chk("rst_wb_en", 32'(wb_en), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_err", 32'(err_flag), 32'd0);
      act      = 1'b0;
      t_done   = -1;
      t_wb     = -1;
      t_pulse  = -1;
      m_inst   = '0;
      m_wbdata = '0;
      m_err    = 1'b0;
    end else begin
      exp_ur = '1;
      if (act && cyc >= t0 + 2 && t_done < 0) exp_ur[m_sel] = 1'b0;
      chk("m_busy", 32'(busy), 32'(act));
      chk("m_ready", 32'(issue_ready), 32'(!act));
      chk("m_unit_reset", 32'(unit_reset), 32'(exp_ur));
      chk("m_wb_en", 32'(wb_en), 32'(cyc == t_wb));
      if (cyc == t_wb) chk("m_wb_addr", 32'(wb_addr), 32'(m_dest));
      chk("m_wb_data", wb_data, m_wbdata);
      chk("m_timeout_pulse", 32'(timeout_pulse), 32'(cyc == t_pulse));
      chk("m_err_flag", 32'(err_flag), 32'(m_err));
      chk("m_inst_num", 32'(unit_inst_num), 32'(m_inst));

      if (!act) begin
        if (issue_valid) begin
          if (int'(issue_unit) >= int'(N)) begin
            t_pulse = cyc + 1;
            m_err   = 1'b1;
          end else begin
            act      = 1'b1;
            t0       = cyc;
            t_done   = -1;
            m_sel    = int'(issue_unit);
            m_dest   = issue_dest;
            m_writes = issue_writes;
            m_inst   = issue_inst_num;
          end
        end
      end else if (t_done >= 0) begin
        if (cyc == t_done + 1) act = 1'b0;
      end else if (cyc >= t0 + 2) begin
        if (unit_completed[m_sel]) begin
          t_done   = cyc;
          m_wbdata = unit_out[32*m_sel +: 32];
          if (m_writes && m_dest != 5'd0) t_wb = cyc + 1;
        end else if (cyc - t0 - 1 == int'(T)) begin
          t_pulse = cyc + 1;
          m_err   = 1'b1;
          act     = 1'b0;
        end
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Directed instruction: selected element completes on WAIT cycle `lat`
  // (lat > T means never). It also asserts a stale completed during START.
  // Other elements assert `noise` with result DEADBEEF throughout.
  // ---------------------------------------------------------------------------
  task automatic run_inst(input int u, input logic [4:0] d, input logic w,
                          input logic [31:0] data, input logic [5:0] inst,
                          input int lat, input logic [N-1:0] noise);
    logic [N-1:0] selm;
    logic [N-1:0] m;
    int last;
    selm = N'(1) << u;
    m    = ~selm;
    last = (lat <= int'(T)) ? 3 + lat : 3 + int'(T);
    tick();
    issue_valid    = 1'b1;
    issue_unit     = UW'(u);
    issue_dest     = d;
    issue_writes   = w;
    issue_inst_num = inst;
    unit_completed = noise & m;
    for (int i = 0; i < int'(N); i++) unit_out[32*i +: 32] = 32'hDEAD_BEEF;
    for (int c = 1; c <= last; c++) begin
      tick();
      issue_valid    = 1'b0;
      unit_completed = noise & m;
      unit_out[32*u +: 32] = $urandom;
      if (c == 1) begin
        unit_completed = unit_completed | selm;
        unit_out[32*u +: 32] = 32'hBAD0_0000;
      end
      if (c == 1 + lat) begin
        unit_completed = unit_completed | selm;
        unit_out[32*u +: 32] = data;
      end
      @(negedge clk);
      if (c == 1) begin
        chk("d_start_busy", 32'(busy), 32'd1);
        chk("d_start_unit_reset", 32'(unit_reset), 32'hF);
        chk("d_start_inst", 32'(unit_inst_num), 32'(inst));
      end
      if (c == 2) chk("d_wait_unit_reset", 32'(unit_reset), 32'(m));
      if (lat <= int'(T)) begin
        if (c == 2 + lat) begin
          chk("d_wb_en", 32'(wb_en), 32'(w && d != 5'd0));
          chk("d_wb_data", wb_data, data);
          chk("d_wb_unit_reset", 32'(unit_reset), 32'hF);
          chk("d_wb_no_pulse", 32'(timeout_pulse), 32'd0);
          if (w && d != 5'd0) chk("d_wb_addr", 32'(wb_addr), 32'(d));
        end
        if (c == 3 + lat) begin
          chk("d_done_ready", 32'(issue_ready), 32'd1);
          chk("d_done_wb_en", 32'(wb_en), 32'd0);
          chk("d_done_wb_data_hold", wb_data, data);
        end
      end else begin
        if (c == 1 + int'(T)) chk("d_to_unit_reset", 32'(unit_reset), 32'(m));
        if (c == 2 + int'(T)) begin
          chk("d_to_pulse", 32'(timeout_pulse), 32'd1);
          chk("d_to_err", 32'(err_flag), 32'd1);
          chk("d_to_busy", 32'(busy), 32'd0);
          chk("d_to_unit_reset_back", 32'(unit_reset), 32'hF);
          chk("d_to_no_wb", 32'(wb_en), 32'd0);
        end
        if (c == 3 + int'(T)) begin
          chk("d_to_pulse_end", 32'(timeout_pulse), 32'd0);
          chk("d_to_err_sticky", 32'(err_flag), 32'd1);
        end
      end
    end
    unit_completed = '0;
  endtask

  initial begin
    reset          = 1'b1;
    issue_valid    = 1'b0;
    issue_unit     = '0;
    issue_inst_num = '0;
    issue_dest     = '0;
    issue_writes   = 1'b0;
    unit_completed = '0;
    unit_out       = '0;

    repeat (3) @(negedge clk);
    chk("reset_unit_reset", 32'(unit_reset), 32'hF);
    chk("reset_ready", 32'(issue_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wb_addr", 32'(wb_addr), 32'd0);
    chk("reset_inst", 32'(unit_inst_num), 32'd0);
    chk("reset_pulse", 32'(timeout_pulse), 32'd0);
    tick();
    reset = 1'b0;

    run_inst(0, 5'd5, 1'b1, 32'h0000_0007, 6'd12, 2, 4'b0000);
    run_inst(0, 5'd0, 1'b1, 32'h0000_0099, 6'd1, 2, 4'b0000);
    run_inst(2, 5'd9, 1'b0, 32'h0000_0042, 6'd2, 2, 4'b0000);
    run_inst(2, 5'd6, 1'b1, 32'h1111_1111, 6'd4, 99, 4'b1011);
    run_inst(1, 5'd8, 1'b1, 32'h0000_1234, 6'd5, 2, 4'b1000);
    run_inst(3, 5'd10, 1'b1, 32'h0000_CAFE, 6'd6, int'(T), 4'b0111);

    // Reset while an instruction sits in WAIT.
    tick();
    issue_valid = 1'b1; issue_unit = 2'd0; issue_dest = 5'd7;
    issue_writes = 1'b1; issue_inst_num = 6'd3;
    tick();
    issue_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_unit_reset", 32'(unit_reset), 32'hF);
    chk("mid_rst_err_clear", 32'(err_flag), 32'd0);
    tick();
    reset = 1'b0;
    unit_completed = 4'b0001;
    unit_out[31:0] = 32'h0000_0055;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_rst_no_wb", 32'(wb_en), 32'd0);
    end
    unit_completed = '0;
    run_inst(0, 5'd5, 1'b1, 32'h0000_0077, 6'd9, 1, 4'b0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset          = ($urandom_range(0, 299) == 0);
      issue_valid    = ($urandom_range(0, 2) != 0);
      issue_unit     = UW'($urandom_range(0, N - 1));
      issue_inst_num = 6'($urandom);
      issue_dest     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      issue_writes   = 1'($urandom);
      for (int i = 0; i < int'(N); i++) begin
        unit_completed[i]    = ($urandom_range(0, 2) == 0);
        unit_out[32*i +: 32] = $urandom;
      end
    end
    tick();
    reset       = 1'b0;
    issue_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
